// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: 8-bit binary to 3-digit BCD converter (double-dabble) with a
// time-multiplexed active-low 7-segment scan. Define LZB_EN for leading-zero blanking.
module bcd_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] DataIn,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] bai,
    output logic [3:0] shi,
    output logic [3:0] ge,
    output logic [6:0] seg,
    output logic [2:0] dig_sel
);
    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_nx;
    logic [7:0]      bin;
    logic [11:0]     bcd, adj;
    logic [2:0]      step;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic            last;
    logic [3:0]      cur;
    logic            blank;
    logic [6:0]      seg_nx;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            default: dec = 7'h7F;
        endcase
    endfunction

    // add-3 correction on every nibble, evaluated in parallel on pre-add values
    always_comb begin
        adj = {bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8],
               bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4],
               bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0]};
    end

    // conversion state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: IDLE -> SHIFT (8 steps) -> DONE -> IDLE; load ignored outside IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = load ? SHIFT : IDLE;
            SHIFT:   state_nx = (step == 3'd7) ? DONE : SHIFT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // conversion datapath and handshake; results only update from DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            bcd  <= '0;
            step <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            bai  <= '0;
            shi  <= '0;
            ge   <= '0;
        end else begin
            busy <= state != IDLE;
            done <= state == DONE;
            if (state == IDLE && load) begin
                bin  <= DataIn;
                bcd  <= '0;
                step <= '0;
            end else if (state == SHIFT) begin
                {bcd, bin} <= {adj, bin} << 1;
                step       <= step + 3'd1;
            end
            if (state == DONE) {bai, shi, ge} <= bcd;
        end
    end

    assign last = cnt == CW'(SCAN_DIV - 1);

    // pick the digit under the scan index and optionally blank leading zeros
    always_comb begin
        cur = idx == 2'd2 ? bai : idx == 2'd1 ? shi : ge;
`ifdef LZB_EN
        blank = (idx == 2'd2 && bai == 4'd0) || (idx == 2'd1 && bai == 4'd0 && shi == 4'd0);
`else
        blank = 1'b0;
`endif
        seg_nx = blank ? 7'h7F : dec(cur);
    end

    // free-running scan divider, digit index and registered display drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            seg     <= 7'h7F;
            dig_sel <= 3'b111;
        end else begin
            cnt     <= last ? '0 : cnt + CW'(1);
            idx     <= last ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : idx;
            seg     <= seg_nx;
            dig_sel <= ~(3'b001 << idx);
        end
    end
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: directed checks of conversion timing, handshake, reset abort and scan.
module tb_bcd_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] DataIn;
    logic       load;
    logic       busy, done;
    logic [3:0] bai, shi, ge;
    logic [6:0] seg;
    logic [2:0] dig_sel;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic [7:0]  d;
        logic [11:0] e;
    } vec_t;

    bcd_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .DataIn(DataIn), .load(load), .busy(busy), .done(done),
        .bai(bai), .shi(shi), .ge(ge), .seg(seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic conv(input logic [7:0] d, input logic [11:0] e);
        int nd = 0;
        @(negedge clk);
        DataIn = d;
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            nd += int'(done);
            if (k == 1) chk("busy_start", 32'(busy), 1);
            if (k == 8) chk("no_early_done", 32'(done), 0);
            if (k == 9) begin
                chk("done_lat9", 32'(done), 1);
                chk("digits", 32'({bai, shi, ge}), 32'(e));
            end
            if (k == 10) chk("busy_end", 32'(busy), 0);
        end
        chk("done_count", 32'(nd), 1);
    endtask

    task automatic align();
        logic [2:0] prev = dig_sel;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dig_sel == 3'b110 && prev != 3'b110) return;
            prev = dig_sel;
        end
        chk("scan_align", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[8];
        logic [2:0] es[3] = '{3'b110, 3'b101, 3'b011};
        logic [6:0] eg[3] = '{7'h30, 7'h24, 7'h79};
        logic [6:0] lz[3];
        int         nd;
        tbl[0] = '{8'd255, 12'h255};
        tbl[1] = '{8'd0,   12'h000};
        tbl[2] = '{8'd199, 12'h199};
        tbl[3] = '{8'd128, 12'h128};
        tbl[4] = '{8'd99,  12'h099};
        tbl[5] = '{8'd10,  12'h010};
        tbl[6] = '{8'd200, 12'h200};
        tbl[7] = '{8'd37,  12'h037};
`ifdef LZB_EN
        lz = '{7'h78, 7'h7F, 7'h7F};
`else
        lz = '{7'h78, 7'h40, 7'h40};
`endif
        rst_n  = 1'b0;
        load   = 1'b0;
        DataIn = 8'd0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_digits", 32'({bai, shi, ge}), 0);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dig_sel", 32'(dig_sel), 32'b111);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_scan_sel", 32'(dig_sel), 32'b110);
        chk("first_scan_seg", 32'(seg), 32'h40);

        for (int i = 0; i < 8; i++) conv(tbl[i].d, tbl[i].e);

        nd = 0;
        @(negedge clk);
        DataIn = 8'd0;
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        DataIn = 8'd199;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            nd += int'(done);
            if (k == 9) begin
                chk("b2b_done1", 32'(done), 1);
                chk("b2b_digits1", 32'({bai, shi, ge}), 32'h000);
            end
            if (k == 10) load = 1'b0;
            if (k == 19) begin
                chk("b2b_done2", 32'(done), 1);
                chk("b2b_digits2", 32'({bai, shi, ge}), 32'h199);
            end
        end
        chk("b2b_done_count", 32'(nd), 2);

        nd = 0;
        @(negedge clk);
        DataIn = 8'd100;
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            nd += int'(done);
            if (k == 3) begin
                DataIn = 8'd37;
                load   = 1'b1;
            end
            if (k == 4) load = 1'b0;
            if (k == 9) chk("ign_digits", 32'({bai, shi, ge}), 32'h100);
        end
        chk("ign_done_count", 32'(nd), 1);

        @(negedge clk);
        DataIn = 8'd128;
        load   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_digits", 32'({bai, shi, ge}), 0);
        chk("abort_seg", 32'(seg), 32'h7F);
        chk("abort_dig_sel", 32'(dig_sel), 32'b111);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            nd += int'(done);
        end
        chk("abort_no_done", 32'(nd), 0);
        conv(8'd128, 12'h128);

        conv(8'd123, 12'h123);
        align();
        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk("scan_sel", 32'(dig_sel), 32'(es[(i / 4) % 3]));
            chk("scan_seg", 32'(seg), 32'(eg[(i / 4) % 3]));
        end

        conv(8'd7, 12'h007);
        align();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i % 4 == 0) chk("lzb_seg", 32'(seg), 32'(lz[i / 4]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
